// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the main-memory arbiter:
//   state_t      - arbiter FSM state encoding
//   LINE_OFFSET  - number of byte-offset bits inside one 128-bit line
//   GRANT_I/D    - encoding of the granted side (instruction / data)
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LINE_OFFSET = 4;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational from the
// request lines; the last_grant register only advances when the owner
// enables arbitration and some request is present.
//   clk, rstn   - clock, asynchronous active-low reset
//   en          - arbitration enable (owner is idle and can accept a grant)
//   req_i/req_d - instruction-side / data-side requests
//   gnt_valid   - at least one request present
//   gnt         - granted side (GRANT_I or GRANT_D)
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_valid,
    output logic gnt
);

    logic last_grant;

    always_comb begin
        gnt_valid = req_i | req_d;
        if (req_i && req_d) begin
            // Tie: the side that did not win last time goes next.
            gnt = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else begin
            gnt = req_d ? GRANT_D : GRANT_I;
        end
    end

    // Reset to GRANT_D so that the first tie after reset goes to the I side.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= GRANT_D;
        end else if (en && gnt_valid) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one 128-bit main-memory port between the instruction refill path
// (I side, read only) and the data cache (D side, read or write). Each
// transfer runs IDLE -> MEM -> RESP; a watchdog aborts a MEM phase that sees
// no mem_ready within TIMEOUT cycles and flags resp_err. All outputs are
// registered.
//   clk, rstn                 - clock, asynchronous active-low reset
//   ireq_valid/ireq_addr      - I-side line read request (held until response)
//   iresp_valid/iresp_data    - I-side one-cycle done pulse / line (held)
//   dreq_valid/we/addr/wdata  - D-side request (held until response)
//   dresp_valid/dresp_rdata   - D-side done pulse / read line (reads only)
//   resp_err                  - accompanies a response pulse on timeout abort
//   mem_req/we/addr/wdata     - memory request, stable while mem_req is high
//   mem_ready/mem_rdata       - memory handshake and read data
//   busy                      - arbiter is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_valid,
    output logic [LINE_W-1:0] iresp_data,
    input  logic              dreq_valid,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [LINE_W-1:0] dreq_wdata,
    output logic              dresp_valid,
    output logic [LINE_W-1:0] dresp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    // Last MEM-cycle count at which a missing mem_ready triggers the abort;
    // the timer is 0 in the first MEM cycle, so mem_req stays up TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_d;
    logic              side, side_d;
    logic [7:0]        timer, timer_d;
    logic              mem_req_d, mem_we_d, busy_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_d, iresp_data_d, dresp_rdata_d;
    logic              iresp_valid_d, dresp_valid_d, resp_err_d;

    logic gnt_valid, gnt;

    // Byte offset within a line never reaches memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ireq_addr[LINE_OFFSET-1:0], dreq_addr[LINE_OFFSET-1:0]};

    rr_arb2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .en        (state == IDLE),
        .req_i     (ireq_valid),
        .req_d     (dreq_valid),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state;
        side_d        = side;
        timer_d       = timer;
        mem_req_d     = 1'b0;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        iresp_valid_d = 1'b0;
        dresp_valid_d = 1'b0;
        resp_err_d    = 1'b0;
        iresp_data_d  = iresp_data;
        dresp_rdata_d = dresp_rdata;

        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_d   = MEM;
                    side_d    = gnt;
                    timer_d   = '0;
                    mem_req_d = 1'b1;
                    if (gnt == GRANT_D) begin
                        mem_we_d    = dreq_we;
                        mem_addr_d  = {dreq_addr[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                        mem_wdata_d = dreq_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {ireq_addr[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                        mem_wdata_d = '0;
                    end
                end
            end

            MEM: begin
                if (mem_ready) begin
                    state_d = RESP;
                    if (side == GRANT_I) begin
                        iresp_valid_d = 1'b1;
                        iresp_data_d  = mem_rdata;
                    end else begin
                        dresp_valid_d = 1'b1;
                        if (!mem_we) begin
                            dresp_rdata_d = mem_rdata;
                        end
                    end
                end else if (timer == TMO_LAST) begin
                    // Watchdog abort: respond with error, data registers untouched.
                    state_d    = RESP;
                    resp_err_d = 1'b1;
                    if (side == GRANT_I) begin
                        iresp_valid_d = 1'b1;
                    end else begin
                        dresp_valid_d = 1'b1;
                    end
                end else begin
                    timer_d   = timer + 8'd1;
                    mem_req_d = 1'b1;
                end
            end

            RESP: begin
                // Response pulse is visible during this state; no grant here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: the line-wide data registers are reset as well: they are plain
    // registers (not RAM), and the response lines must read 0 after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            side        <= GRANT_I;
            timer       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            iresp_valid <= 1'b0;
            dresp_valid <= 1'b0;
            resp_err    <= 1'b0;
            iresp_data  <= '0;
            dresp_rdata <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            side        <= side_d;
            timer       <= timer_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            iresp_valid <= iresp_valid_d;
            dresp_valid <= dresp_valid_d;
            resp_err    <= resp_err_d;
            iresp_data  <= iresp_data_d;
            dresp_rdata <= dresp_rdata_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level model predicts the
// winner of each request (round-robin on ties), the aligned address, the
// number of mem_req cycles, latency, error flag and the resulting data lines.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_valid;
    logic [LINE_W-1:0] iresp_data;
    logic              dreq_valid;
    logic              dreq_we;
    logic [ADDR_W-1:0] dreq_addr;
    logic [LINE_W-1:0] dreq_wdata;
    logic              dresp_valid;
    logic [LINE_W-1:0] dresp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
    logic              busy;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .iresp_valid (iresp_valid),
        .iresp_data  (iresp_data),
        .dreq_valid  (dreq_valid),
        .dreq_we     (dreq_we),
        .dreq_addr   (dreq_addr),
        .dreq_wdata  (dreq_wdata),
        .dresp_valid (dresp_valid),
        .dresp_rdata (dresp_rdata),
        .resp_err    (resp_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                last_was_d;   // side that won the most recent grant
    logic [LINE_W-1:0] exp_idata;
    logic [LINE_W-1:0] exp_drdata;
    bit                saw_i, saw_d; // used by the reset test

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        last_was_d = 1'b1;
        exp_idata  = '0;
        exp_drdata = '0;
    endtask

    // Runs one transaction starting at a negedge. The delay argument is the
    // number of MEM cycles without mem_ready before memory answers; a delay of
    // TIMEOUT or more means it never answers. The final argument is the read
    // data memory returns.
    task automatic do_txn(input logic vi, input logic vd, input logic we,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [127:0] wd, input int delay,
                          input logic [127:0] line);
        bit          win_d, exp_we, exp_err, done;
        logic [31:0] exp_addr;
        int          exp_mem, m;

        win_d      = (vi && vd) ? !last_was_d : vd;
        last_was_d = win_d;
        exp_addr   = (win_d ? da : ia) & 32'hFFFF_FFF0;
        exp_we     = win_d && we;
        exp_err    = (delay >= TIMEOUT);
        exp_mem    = exp_err ? TIMEOUT : delay + 1;

        ireq_valid = vi;
        ireq_addr  = ia;
        dreq_valid = vd;
        dreq_we    = we;
        dreq_addr  = da;
        dreq_wdata = wd;

        m    = 0;
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (iresp_valid || dresp_valid) begin
                check("resp_side", 128'({iresp_valid, dresp_valid}), win_d ? 128'd1 : 128'd2);
                check("resp_err", 128'(resp_err), 128'(exp_err));
                check("mem_cycles", 128'(m), 128'(exp_mem));
                check("latency", 128'(k), 128'(exp_mem + 1));
                if (!exp_err) begin
                    if (!win_d) exp_idata = line;
                    else if (!we) exp_drdata = line;
                end
                check("iresp_data", iresp_data, exp_idata);
                check("dresp_rdata", dresp_rdata, exp_drdata);
                if (win_d) dreq_valid = 1'b0;
                else ireq_valid = 1'b0;
                done = 1'b1;
            end else if (mem_req) begin
                m++;
                check("mem_addr", 128'(mem_addr), 128'(exp_addr));
                check("mem_we", 128'(mem_we), 128'(exp_we));
                if (exp_we) check("mem_wdata", mem_wdata, wd);
            end
            // Memory responder: stray ready outside MEM must be ignored.
            mem_rdata = rand_line();
            mem_ready = 1'b0;
            if (mem_req && !done) begin
                if (m == delay + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = line;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) check("resp_timeout", 128'd0, 128'd1);
        @(negedge clk);
        check("busy_after", 128'(busy), 128'd0);
        check("single_pulse", 128'({iresp_valid, dresp_valid}), 128'd0);
    endtask

    initial begin
        logic [127:0] line_a;
        logic [127:0] wd_a;
        int           wait_cnt;

        rstn       = 1'b0;
        ireq_valid = 1'b0;
        ireq_addr  = '0;
        dreq_valid = 1'b0;
        dreq_we    = 1'b0;
        dreq_addr  = '0;
        dreq_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        model_reset();
        repeat (2) @(negedge clk);

        check("rst_mem_req", 128'(mem_req), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_resp", 128'({iresp_valid, dresp_valid, resp_err}), 128'd0);
        check("rst_iresp_data", iresp_data, 128'd0);
        check("rst_dresp_rdata", dresp_rdata, 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Ties straight after reset: I, D, I, D
        for (int t = 0; t < 4; t++) begin
            do_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   rand_line(), 1, rand_line());
        end

        // Directed I read
        line_a = {32'hDEADBEEF, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF};
        do_txn(1'b1, 1'b0, 1'b0, 32'h0000010C, 32'h0, '0, 1, line_a);

        // Directed D write: dresp_rdata must not change
        wd_a = {32'h12345678, 32'hAAAAAAAA, 32'hBADA881E, 32'h0};
        do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h00000204, wd_a, 2, rand_line());

        // Minimum latency and watchdog abort
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, $urandom, rand_line(), 0, rand_line());
        do_txn(1'b1, 1'b0, 1'b0, $urandom, 32'h0, '0, TIMEOUT + 5, rand_line());
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, $urandom, rand_line(), TIMEOUT - 1, rand_line());

        // mem_ready while idle produces nothing
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        mem_ready  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_ready_resp", 128'({iresp_valid, dresp_valid, mem_req}), 128'd0);
            check("idle_ready_busy", 128'(busy), 128'd0);
        end
        mem_ready = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = $urandom_range(1, 3);
            do_txn(1'(sel & 1), 1'(sel >> 1), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   rand_line(), $urandom_range(0, TIMEOUT + 1), rand_line());
        end

        // Reset in the middle of MEM
        mem_ready  = 1'b0;
        ireq_valid = 1'b1;
        ireq_addr  = $urandom;
        wait_cnt   = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!mem_req && wait_cnt < 20);
        check("rst_test_mem_req_seen", 128'(mem_req), 128'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("async_rst_mem_req", 128'(mem_req), 128'd0);
        check("async_rst_busy", 128'(busy), 128'd0);
        check("async_rst_resp", 128'({iresp_valid, dresp_valid, resp_err}), 128'd0);
        model_reset();
        ireq_valid = 1'b0;
        saw_i = 1'b0;
        saw_d = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (iresp_valid) saw_i = 1'b1;
            if (dresp_valid) saw_d = 1'b1;
        end
        check("no_resp_after_rst", 128'({saw_i, saw_d}), 128'd0);
        check("idle_after_rst", 128'(busy), 128'd0);
        do_txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, rand_line(), 0, rand_line());
        do_txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, rand_line(), 1, rand_line());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates one shared 128-bit main-memory port between the instruction-fetch refill path and the data-memory path. It sequences each transfer as request, wait for memory ready, then a one-cycle response, and sits between InsFetch's cache-miss side and the data cache. It uses round-robin arbitration on simultaneous requests and a watchdog that terminates hung transfers with an error.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 128, line width (4 x 32-bit words)
TIMEOUT, 255, max cycles waiting for mem_ready before abort (8-bit counter; TIMEOUT >= 1)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
ireq_valid  in  1  I-side line read request; held until iresp_valid
ireq_addr  in  ADDR_W  I-side byte address
iresp_valid  out  1  one-cycle pulse: I transfer done
iresp_data  out  LINE_W  I-side line; valid with iresp_valid, held after
dreq_valid  in  1  D-side request; held until dresp_valid
dreq_we  in  1  1 = line write, 0 = line read
dreq_addr  in  ADDR_W  D-side byte address
dreq_wdata  in  LINE_W  D-side write line
dresp_valid  out  1  one-cycle pulse: D transfer done
dresp_rdata  out  LINE_W  D-side read line; updated only by D reads
resp_err  out  1  pulses with iresp_valid/dresp_valid on timeout abort
mem_req  out  1  memory request, held until mem_ready sampled high
mem_we  out  1  write strobe, stable while mem_req
mem_addr  out  ADDR_W  line-aligned address, {addr[ADDR_W-1:4],4'b0}
mem_wdata  out  LINE_W  write data, stable while mem_req
mem_ready  in  1  memory accepts/completes the transfer this cycle
mem_rdata  in  LINE_W  read data, valid when mem_ready=1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rstn=0) forces state=IDLE, all outputs 0, data registers 0, last_grant=D, timer=0. Reset mid-transfer discards the transfer; no response is produced.
- States: IDLE, MEM, RESP. All outputs are registered.
- IDLE: if exactly one valid is high, grant it. If both are high, grant the side opposite last_grant; after reset the I side wins the first tie.
- On grant: latch addr, we (I side: we=0), and wdata; update last_grant; go to MEM. mem_req=1 from the next cycle.
- MEM: mem_req held with stable addr/we/wdata. On the cycle mem_ready=1, capture mem_rdata into the granted side's data register (reads only), deassert mem_req next cycle, go to RESP.
- MEM timer: counts cycles in MEM. If the count reaches TIMEOUT with no mem_ready, drop mem_req, set err, go to RESP. On abort, data registers are unchanged.
- RESP: pulse the granted side's resp_valid for exactly one cycle, with resp_err=err, then return to IDLE.
- A new grant is not possible in the RESP cycle. The requester must drop valid on the cycle after the response or it will be re-arbitrated.
- Minimum latency: valid at edge t -> mem_req at t+1; mem_ready=1 at t+1 -> resp_valid at t+2, IDLE at t+3.
- A requester dropping valid mid-transfer is ignored: the transfer completes and its response still pulses.
- mem_ready high while in IDLE or RESP is ignored.
- Simultaneous grant with ready: not possible, since mem_req only rises after a grant.
- Back-to-back ties alternate I, D, I, D.

Decomposition:
- Package mem_pkg holds:
  - state encoding (IDLE=2'd0, MEM=2'd1, RESP=2'd2)
  - LINE_OFFSET=4
  - GRANT_I/GRANT_D constants
- Natural sub-module rr_arb2: 2-requester round-robin with a last_grant register, driven by an enable from IDLE.
- Datapath registers and the FSM stay in mem_arbiter.

Test Plan:
- I read: ireq_addr=32'h0000010C, mem_ready high on the second MEM cycle, mem_rdata={32'hDEADBEEF,32'hABABABAB,32'hCDCDCDCD,32'hEFEFEFEF} -> mem_addr=32'h00000100, mem_we=0, iresp_valid pulses once, iresp_data equals that line, resp_err=0.
- D write: dreq_we=1, dreq_addr=32'h00000204, dreq_wdata={32'h12345678,32'hAAAAAAAA,32'hBADA881E,32'h0} -> mem_we=1, mem_addr=32'h00000200, mem_wdata matches, dresp_valid pulse, dresp_rdata unchanged.
- Tie after reset: both valid continuously for 4 transfers -> grant order I, D, I, D; exactly one resp pulse per transfer.
- Timeout: TIMEOUT=8, mem_ready tied 0 -> mem_req high for exactly 8 cycles, then a resp pulse with resp_err=1 and busy low the cycle after.
- Reset mid-MEM: assert rstn=0 while mem_req=1 -> mem_req, busy, and resp outputs 0 immediately (async). After release, state is IDLE and the next tie grants I.
- Minimum latency: mem_ready held 1 -> resp_valid exactly 2 cycles after the request edge; mem_ready while IDLE produces no response.
